// File: rtl/pulpemu_spi_flash_model.sv
// QSPI flash responder for the PULP emulator board.
// Decodes 03/6B/9F/05 and serves bytes from an FPGA memory port.
module pulpemu_spi_flash_model #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [23:0] JEDEC_ID  = 24'hC22016,
  parameter int unsigned DUMMY_CYC = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_csn_i,
  input  logic              spi_sck_i,
  input  logic [3:0]        spi_sdio_i,
  output logic [3:0]        spi_sdio_o,
  output logic [3:0]        spi_sdio_oe_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned SH_W =
    (ADDR_W > 24) ? ADDR_W : 24;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY,
    DATA, ID, STAT, IGNORE
  } state_e;

  logic [1:0]  csn_q, sck_q;
  logic [3:0]  sdio1_q, sdio2_q;
  logic        sck_prev_q;
  logic [1:0]  vld_q;
  logic        armed_q;
  logic        csn_s, sck_rise, sck_fall;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [SH_W-1:0]     sh_q, sh_d, sh_nxt;
  logic                quad_q, quad_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                req_q, req_d;
  logic [MEM_LAT-1:0]  pend_q, pend_d;
  logic [7:0]          buf_q, buf_d;
  logic [7:0]          out_q, out_d;
  logic [2:0]          dcnt_q, dcnt_d;
  logic [3:0]          sdio_q, sdio_d;
  logic                dlast;

  assign csn_s    = csn_q[1];
  assign sck_rise = sck_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_q[1] & sck_prev_q;

  // Pad synchronizers; armed_q blocks a CS already low at reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csn_q      <= 2'b11;
      sck_q      <= 2'b00;
      sdio1_q    <= '0;
      sdio2_q    <= '0;
      sck_prev_q <= 1'b0;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      csn_q      <= {csn_q[0], spi_csn_i};
      sck_q      <= {sck_q[0], spi_sck_i};
      sdio1_q    <= spi_sdio_i;
      sdio2_q    <= sdio1_q;
      sck_prev_q <= sck_q[1];
      vld_q      <= {vld_q[0], 1'b1};
      if (vld_q[1] && csn_s) armed_q <= 1'b1;
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      quad_q  <= 1'b0;
      addr_q  <= '0;
      maddr_q <= '0;
      req_q   <= 1'b0;
      pend_q  <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      dcnt_q  <= '0;
      sdio_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      quad_q  <= quad_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      dcnt_q  <= dcnt_d;
      sdio_q  <= sdio_d;
    end
  end

  // Next state: shift-in on SCK rise, drive on fall, CS high wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    quad_d  = quad_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    req_d   = 1'b0;
    pend_d  = MEM_LAT'({pend_q, req_q});
    buf_d   = buf_q;
    out_d   = out_q;
    dcnt_d  = dcnt_q;
    sdio_d  = sdio_q;
    sh_nxt  = {sh_q[SH_W-2:0], sdio2_q[0]};
    dlast   = quad_q ? (dcnt_q == 3'd1)
                     : (dcnt_q == 3'd7);
    if (pend_q[MEM_LAT-1]) buf_d = mem_rdata_i;
    if (csn_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      buf_d   = '0;
      out_d   = '0;
      dcnt_d  = '0;
      sdio_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            sh_d  = sh_nxt;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = '0;
              unique case (sh_nxt[7:0])
                8'h03: begin
                  state_d = ADDR;
                  quad_d  = 1'b0;
                end
                8'h6B: begin
                  state_d = ADDR;
                  quad_d  = 1'b1;
                end
                8'h9F: begin
                  state_d = ID;
                  sh_d    = '0;
                  sh_d[SH_W-1 -: 24] = JEDEC_ID;
                end
                8'h05: begin
                  state_d = STAT;
                  sh_d    = '0;
                end
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            sh_d  = sh_nxt;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(ADDR_W - 1)) begin
              cnt_d   = '0;
              dcnt_d  = '0;
              req_d   = 1'b1;
              maddr_d = sh_nxt[ADDR_W-1:0];
              addr_d  = sh_nxt[ADDR_W-1:0]
                      + ADDR_W'(1);
              state_d = quad_q ? DUMMY : DATA;
            end
          end
        end
        DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(DUMMY_CYC - 1)) begin
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sck_fall) begin
            if (dcnt_q == 3'd0) begin
              req_d   = 1'b1;
              maddr_d = addr_q;
              addr_d  = addr_q + ADDR_W'(1);
              if (quad_q) begin
                sdio_d = buf_q[7:4];
                out_d  = {buf_q[3:0], 4'b0};
              end else begin
                sdio_d = {2'b0, buf_q[7], 1'b0};
                out_d  = {buf_q[6:0], 1'b0};
              end
            end else if (quad_q) begin
              sdio_d = out_q[7:4];
              out_d  = {out_q[3:0], 4'b0};
            end else begin
              sdio_d = {2'b0, out_q[7], 1'b0};
              out_d  = {out_q[6:0], 1'b0};
            end
            dcnt_d = dlast ? 3'd0 : dcnt_q + 3'd1;
          end
        end
        ID, STAT: begin
          if (sck_fall) begin
            sdio_d = {2'b0, sh_q[SH_W-1], 1'b0};
            sh_d   = {sh_q[SH_W-2:0], 1'b0};
          end
        end
        IGNORE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pad enables follow the FSM so CS high releases them at once.
  always_comb begin
    spi_sdio_oe_o = 4'b0000;
    if (state_q == DATA && quad_q)
      spi_sdio_oe_o = 4'b1111;
    else if (state_q == DATA || state_q == ID ||
             state_q == STAT)
      spi_sdio_oe_o = 4'b0010;
  end

  assign spi_sdio_o = sdio_q;
  assign mem_req_o  = req_q;
  assign mem_addr_o = maddr_q;
  assign busy_o     = ~csn_s;

endmodule
